// File: rtl/hazard_resolution_unit_pkg.sv
// Shared types for the hazard resolution unit: forwarding selects, control states
// and named bit positions within the detector's hazard vector.
package hazard_resolution_unit_pkg;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        RUN,
        LD_STALL,
        BR_FLUSH,
        MD_WAIT
    } hzu_state_t;

    localparam int unsigned HAZ_W           = 11;
    localparam int unsigned HAZ_A_S3        = 0;
    localparam int unsigned HAZ_A_S2        = 1;
    localparam int unsigned HAZ_B_S2        = 2;
    localparam int unsigned HAZ_B_S3        = 3;
    localparam int unsigned HAZ_CMP_S2      = 4;
    localparam int unsigned HAZ_CMP_S3      = 5;
    localparam int unsigned HAZ_R0_S2       = 6;
    localparam int unsigned HAZ_R0_S3       = 7;
    localparam int unsigned HAZ_SW_S2       = 8;
    localparam int unsigned HAZ_SW_S3       = 9;
    localparam int unsigned HAZ_SW_ARITH_S2 = 10;

    // The nearer producer (EX/MEM) always takes precedence over MEM/WB.
    function automatic fwd_sel_t fwd_pick(input logic i_near, input logic i_far);
        if (i_near)
            return FWD_EXMEM;
        else if (i_far)
            return FWD_MEMWB;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_resolution_unit_md.sv
// Down-counter that times the MULT/DIV freeze; loads a start value and
// decrements towards zero, flagging when it gets there.
module md_freeze_counter (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_load,
    input  logic [3:0] i_load_val,
    input  logic       i_dec,
    output logic [3:0] o_count,
    output logic       o_zero
);

    logic [3:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_count <= '0;
        else if (i_load)
            r_count <= i_load_val;
        else if (i_dec && (r_count != '0))
            r_count <= r_count - 4'd1;
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == '0);

endmodule

// File: rtl/hazard_resolution_unit.sv
// Turns the detector's hazard vector and stall request into pipeline enables,
// bubble/flush controls, registered EX forwarding selects and the MULT/DIV freeze.
module hazard_resolution_unit
    import hazard_resolution_unit_pkg::*;
#(
    parameter int unsigned MD_LATENCY = 4,
    parameter int unsigned PERF_W     = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [HAZ_W-1:0]  i_haz,
    input  logic              i_stall,
    input  logic              i_branch_taken,
    input  logic              i_md_start,
    output logic              o_pc_en,
    output logic              o_ifid_en,
    output logic              o_ifid_flush,
    output logic              o_idex_en,
    output logic              o_idex_bubble,
    output logic [1:0]        o_fwd_a,
    output logic [1:0]        o_fwd_b,
    output logic [1:0]        o_fwd_cmp,
    output logic [1:0]        o_fwd_sw,
    output logic [1:0]        o_fwd_r0,
    output logic              o_md_busy,
    output logic [PERF_W-1:0] o_stall_cycles
);

    localparam logic [3:0] MD_LOAD = 4'(MD_LATENCY - 1);

    hzu_state_t        r_state, w_next;
    fwd_sel_t          r_fwd_a, r_fwd_b, r_fwd_cmp, r_fwd_sw, r_fwd_r0;
    logic [PERF_W-1:0] r_stall_cycles;

    logic       w_pc_en, w_ifid_en, w_ifid_flush, w_idex_en, w_idex_bubble, w_md_busy;
    logic       w_md_load, w_md_dec, w_md_zero, w_fwd_clear, w_fwd_hold;
    logic [3:0] w_md_count;

    md_freeze_counter u_md_cnt (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_md_load),
        .i_load_val (MD_LOAD),
        .i_dec      (w_md_dec),
        .o_count    (w_md_count),
        .o_zero     (w_md_zero)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_state <= RUN;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next        = r_state;
        w_pc_en       = 1'b1;
        w_ifid_en     = 1'b1;
        w_ifid_flush  = 1'b0;
        w_idex_en     = 1'b1;
        w_idex_bubble = 1'b0;
        w_md_busy     = 1'b0;
        w_md_load     = 1'b0;
        w_md_dec      = 1'b0;
        w_fwd_clear   = 1'b0;
        w_fwd_hold    = 1'b0;
        if (i_rst) begin
            w_next        = RUN;
            w_pc_en       = 1'b0;
            w_ifid_en     = 1'b0;
            w_idex_en     = 1'b0;
            w_ifid_flush  = 1'b1;
            w_idex_bubble = 1'b1;
        end else begin
            unique case (r_state)
                RUN: begin
                    if (i_branch_taken) begin
                        w_ifid_flush  = 1'b1;
                        w_idex_bubble = 1'b1;
                        w_next        = BR_FLUSH;
                    end else if (i_md_start) begin
                        w_md_load = 1'b1;
                        w_next    = MD_WAIT;
                    end else if (i_stall) begin
                        w_pc_en       = 1'b0;
                        w_ifid_en     = 1'b0;
                        w_idex_bubble = 1'b1;
                        w_next        = LD_STALL;
                    end
                end
                LD_STALL: w_next = RUN;
                BR_FLUSH: begin
                    w_fwd_clear = 1'b1;
                    w_next      = RUN;
                end
                MD_WAIT: begin
                    // Zero-count cycle releases the pipe but selects still hold.
                    w_fwd_hold = 1'b1;
                    if (w_md_zero) begin
                        w_next = RUN;
                    end else begin
                        w_pc_en   = 1'b0;
                        w_ifid_en = 1'b0;
                        w_idex_en = 1'b0;
                        w_md_busy = 1'b1;
                        w_md_dec  = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fwd_a   <= FWD_RF;
            r_fwd_b   <= FWD_RF;
            r_fwd_cmp <= FWD_RF;
            r_fwd_sw  <= FWD_RF;
            r_fwd_r0  <= FWD_RF;
        end else if (w_idex_en && !w_fwd_hold) begin
            if (w_idex_bubble || w_fwd_clear) begin
                r_fwd_a   <= FWD_RF;
                r_fwd_b   <= FWD_RF;
                r_fwd_cmp <= FWD_RF;
                r_fwd_sw  <= FWD_RF;
                r_fwd_r0  <= FWD_RF;
            end else begin
                r_fwd_a   <= fwd_pick(i_haz[HAZ_A_S2], i_haz[HAZ_A_S3]);
                r_fwd_b   <= fwd_pick(i_haz[HAZ_B_S2], i_haz[HAZ_B_S3]);
                r_fwd_cmp <= fwd_pick(i_haz[HAZ_CMP_S2], i_haz[HAZ_CMP_S3]);
                r_fwd_r0  <= fwd_pick(i_haz[HAZ_R0_S2], i_haz[HAZ_R0_S3]);
                r_fwd_sw  <= fwd_pick(i_haz[HAZ_SW_S2] | i_haz[HAZ_SW_ARITH_S2],
                                      i_haz[HAZ_SW_S3]);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_stall_cycles <= '0;
        else if (!w_pc_en && (r_stall_cycles != '1))
            r_stall_cycles <= r_stall_cycles + PERF_W'(1);
    end

    assign o_pc_en        = w_pc_en;
    assign o_ifid_en      = w_ifid_en;
    assign o_ifid_flush   = w_ifid_flush;
    assign o_idex_en      = w_idex_en;
    assign o_idex_bubble  = w_idex_bubble;
    assign o_md_busy      = w_md_busy;
    assign o_fwd_a        = r_fwd_a;
    assign o_fwd_b        = r_fwd_b;
    assign o_fwd_cmp      = r_fwd_cmp;
    assign o_fwd_sw       = r_fwd_sw;
    assign o_fwd_r0       = r_fwd_r0;
    assign o_stall_cycles = r_stall_cycles;

    logic w_unused;
    assign w_unused = ^w_md_count;

endmodule

// File: tb/tb_hazard_resolution_unit.sv
// Random and directed stimulus for hazard_resolution_unit, checked every cycle
// against a cycle-level behavioural model of the control rules.
module tb_hazard_resolution_unit;

    localparam int MD_LAT = 4;
    localparam int PW     = 6;
    localparam int SAT    = (1 << PW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [10:0]   haz = '0;
    logic          stall = 1'b0, br = 1'b0, md = 1'b0;
    logic          pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, md_busy;
    logic [1:0]    fwd_a, fwd_b, fwd_cmp, fwd_sw, fwd_r0;
    logic [PW-1:0] stall_cycles;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hazard_resolution_unit #(.MD_LATENCY(MD_LAT), .PERF_W(PW)) dut (
        .i_clk(clk), .i_rst(rst), .i_haz(haz), .i_stall(stall),
        .i_branch_taken(br), .i_md_start(md),
        .o_pc_en(pc_en), .o_ifid_en(ifid_en), .o_ifid_flush(ifid_flush),
        .o_idex_en(idex_en), .o_idex_bubble(idex_bubble),
        .o_fwd_a(fwd_a), .o_fwd_b(fwd_b), .o_fwd_cmp(fwd_cmp),
        .o_fwd_sw(fwd_sw), .o_fwd_r0(fwd_r0),
        .o_md_busy(md_busy), .o_stall_cycles(stall_cycles)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_freeze = 0;                 // frozen cycles still to come
    bit m_tail = 0, m_after_br = 0, m_after_ld = 0, m_valid = 0;
    int m_fa = 0, m_fb = 0, m_fc = 0, m_fs = 0, m_fr = 0, m_sc = 0;
    int e_pc, e_ifid, e_idex, e_flush, e_bub, e_busy;

    function automatic int pick(input logic near, input logic far);
        return near ? 1 : (far ? 2 : 0);
    endfunction

    task automatic expect_comb();
        e_pc = 1; e_ifid = 1; e_idex = 1; e_flush = 0; e_bub = 0; e_busy = 0;
        if (rst) begin
            e_pc = 0; e_ifid = 0; e_idex = 0; e_flush = 1; e_bub = 1;
        end else if (m_freeze > 0) begin
            e_pc = 0; e_ifid = 0; e_idex = 0; e_busy = 1;
        end else if (m_tail || m_after_br || m_after_ld) begin
            // one-cycle follow-on slots: everything flows, requests ignored
        end else if (br) begin
            e_flush = 1; e_bub = 1;
        end else if (md) begin
        end else if (stall) begin
            e_pc = 0; e_ifid = 0; e_bub = 1;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                expect_comb();
                check("pc_en", pc_en, e_pc);
                check("ifid_en", ifid_en, e_ifid);
                check("idex_en", idex_en, e_idex);
                check("ifid_flush", ifid_flush, e_flush);
                check("idex_bubble", idex_bubble, e_bub);
                check("md_busy", md_busy, e_busy);
                check("fwd_a", fwd_a, m_fa);
                check("fwd_b", fwd_b, m_fb);
                check("fwd_cmp", fwd_cmp, m_fc);
                check("fwd_sw", fwd_sw, m_fs);
                check("fwd_r0", fwd_r0, m_fr);
                check("stall_cycles", stall_cycles, m_sc);
            end
            @(posedge clk);
            expect_comb();
            if (rst) begin
                m_freeze = 0; m_tail = 0; m_after_br = 0; m_after_ld = 0;
                m_fa = 0; m_fb = 0; m_fc = 0; m_fs = 0; m_fr = 0; m_sc = 0;
                m_valid = 1;
            end else if (m_valid) begin
                if (e_pc == 0 && m_sc < SAT) m_sc++;
                if (!(m_freeze > 0 || m_tail)) begin
                    if (e_bub || m_after_br) begin
                        m_fa = 0; m_fb = 0; m_fc = 0; m_fs = 0; m_fr = 0;
                    end else begin
                        m_fa = pick(haz[1], haz[0]);
                        m_fb = pick(haz[2], haz[3]);
                        m_fc = pick(haz[4], haz[5]);
                        m_fr = pick(haz[6], haz[7]);
                        m_fs = pick(haz[8] | haz[10], haz[9]);
                    end
                end
                if (m_freeze > 0) begin
                    m_freeze--;
                    if (m_freeze == 0) m_tail = 1;
                end else if (m_tail || m_after_br || m_after_ld) begin
                    m_tail = 0; m_after_br = 0; m_after_ld = 0;
                end else if (br) begin
                    m_after_br = 1;
                end else if (md) begin
                    m_freeze = MD_LAT - 1;
                end else if (stall) begin
                    m_after_ld = 1;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit r, input bit b, input bit m, input bit s, input logic [10:0] h);
        @(posedge clk);
        #1;
        rst = r; br = b; md = m; stall = s; haz = h;
        #2;
    endtask

    initial begin
        drive(1, 0, 0, 0, 11'h000);
        drive(1, 0, 0, 0, 11'h000);
        check("rst_flush", ifid_flush, 1);
        check("rst_bubble", idex_bubble, 1);
        check("rst_pc_en", pc_en, 0);
        drive(0, 0, 0, 0, 11'h000);
        check("idle_pc_en", pc_en, 1);
        check("idle_idex_en", idex_en, 1);
        check("idle_fwd_a", fwd_a, 0);
        check("idle_stall_cycles", stall_cycles, 0);

        drive(0, 0, 0, 0, 11'h003);
        drive(0, 0, 0, 0, 11'h008);
        check("lit_fwd_a_01", fwd_a, 2'b01);
        drive(0, 0, 0, 0, 11'h300);
        check("lit_fwd_b_10", fwd_b, 2'b10);
        drive(0, 0, 0, 0, 11'h000);
        check("lit_fwd_sw_01", fwd_sw, 2'b01);

        drive(0, 0, 0, 1, 11'h000);
        check("ld_pc_en", pc_en, 0);
        check("ld_bubble", idex_bubble, 1);
        drive(0, 0, 0, 1, 11'h001);
        check("ld_next_pc_en", pc_en, 1);
        check("ld_next_ifid_en", ifid_en, 1);
        check("ld_stall_cycles", stall_cycles, 1);

        drive(0, 1, 0, 1, 11'h000);
        check("br_flush", ifid_flush, 1);
        check("br_pc_en", pc_en, 1);
        drive(0, 0, 0, 1, 11'h010);
        check("brf_pc_en", pc_en, 1);
        check("brf_bubble", idex_bubble, 0);
        drive(0, 0, 0, 0, 11'h000);
        check("brf_fwd_cmp", fwd_cmp, 2'b00);

        drive(0, 0, 0, 0, 11'h001);
        drive(0, 0, 1, 0, 11'h001);
        check("md_start_pc_en", pc_en, 1);
        for (int i = 0; i < MD_LAT - 1; i++) begin
            drive(0, 1, 0, 1, 11'h002);
            check("md_frozen_pc_en", pc_en, 0);
            check("md_frozen_busy", md_busy, 1);
            check("md_frozen_fwd_a", fwd_a, 2'b10);
        end
        drive(0, 0, 0, 0, 11'h000);
        check("md_release_pc_en", pc_en, 1);
        check("md_release_busy", md_busy, 0);
        check("md_stall_cycles", stall_cycles, 4);
        drive(0, 0, 0, 0, 11'h000);
        check("md_tail_fwd_a", fwd_a, 2'b10);

        drive(0, 0, 1, 0, 11'h000);
        drive(0, 0, 0, 0, 11'h000);
        drive(1, 0, 0, 0, 11'h000);
        drive(0, 0, 0, 0, 11'h000);
        check("md_rst_busy", md_busy, 0);
        check("md_rst_pc_en", pc_en, 1);
        check("md_rst_stall_cycles", stall_cycles, 0);

        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 149) == 0),
                  ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 11) == 0),
                  ($urandom_range(0, 4) == 0),
                  11'($urandom));
        end
        drive(0, 0, 0, 0, 11'h000);
        @(posedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
